// File: rtl/stim_pulse_sequencer.sv
// Biphasic stimulation pulse sequencer: turns latched timing parameters into H-bridge switch
// controls with break-before-make dead time, interphase gap and post-pulse electrode shorting.
module stim_pulse_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned NUM_W  = 8,
  parameter int unsigned DEAD_T = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_phase_w,
  input  logic [CNT_W-1:0] i_gap_w,
  input  logic [CNT_W-1:0] i_ipi_w,
  input  logic [NUM_W-1:0] i_num_pulses,
  input  logic             i_polarity,
  output logic             out_sw1_sig,
  output logic             out_sw2_sig,
  output logic             out_sw3_sig,
  output logic             out_sw4_sig,
  output logic             output_ctrl_sig,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    StIdle, StDead1, StPh1, StGap, StPh2, StDead2, StShort, StAbort
  } state_e;

  // Switch order {sw1, sw2, sw3, sw4}
  localparam logic [3:0] SwCath  = 4'b1001;
  localparam logic [3:0] SwAnod  = 4'b0110;
  localparam logic [3:0] SwShort = 4'b0011;

  localparam logic [CNT_W-1:0] DeadCnt = CNT_W'(DEAD_T - 1);
  localparam logic [CNT_W-1:0] DeadLen = CNT_W'(DEAD_T);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] phase_q, gap_q, ipi_q;
  logic [NUM_W-1:0] num_q;
  logic             pol_q;
  logic             start_ok;
  logic             last;
  logic [CNT_W-1:0] phase_cnt, gap_cnt, ipi_cnt;
  logic [3:0]       sw_d, sw_q;
  logic             ctrl_d, ctrl_q, busy_q, done_d, done_q;

  assign start_ok = (state_q == StIdle) && i_en && i_start;
  assign last     = (cnt_q == '0);

  // Counter reload values are duration-1; zero-width phase/ipi clamp to one cycle
  assign phase_cnt = (phase_q == '0) ? '0 : phase_q - 1'b1;
  assign ipi_cnt   = (ipi_q == '0) ? '0 : ipi_q - 1'b1;
  assign gap_cnt   = (gap_q < DeadLen) ? DeadCnt : gap_q - 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StDead1;
          cnt_d   = DeadCnt;
          pulse_d = '0;
        end
      end
      StAbort: begin
        if (last) state_d = StIdle;
        else      cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        // Enable loss wins over any coincident state end
        if (!i_en) begin
          state_d = StAbort;
          cnt_d   = DeadCnt;
        end else if (!last) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          case (state_q)
            StDead1: begin state_d = StPh1;   cnt_d = phase_cnt; end
            StPh1:   begin state_d = StGap;   cnt_d = gap_cnt;   end
            StGap:   begin state_d = StPh2;   cnt_d = phase_cnt; end
            StPh2: begin
              state_d = StDead2;
              cnt_d   = DeadCnt;
              if (pulse_q != '1) pulse_d = pulse_q + 1'b1;
            end
            StDead2: begin state_d = StShort; cnt_d = ipi_cnt;   end
            StShort: begin
              if (num_q == '0 || pulse_q < num_q) begin
                state_d = StDead1;
                cnt_d   = DeadCnt;
              end else begin
                state_d = StIdle;
                done_d  = 1'b1;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  // Outputs decode the next state so the registered pins line up with the state register
  always_comb begin
    sw_d   = 4'b0000;
    ctrl_d = 1'b0;
    case (state_d)
      StPh1: begin
        sw_d   = pol_q ? SwAnod : SwCath;
        ctrl_d = 1'b1;
      end
      StPh2: begin
        sw_d   = pol_q ? SwCath : SwAnod;
        ctrl_d = 1'b1;
      end
      StShort: sw_d = SwShort;
      default: sw_d = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= '0;
      sw_q    <= 4'b0000;
      ctrl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      sw_q    <= sw_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase_q <= '0;
      gap_q   <= '0;
      ipi_q   <= '0;
      num_q   <= '0;
      pol_q   <= 1'b0;
    end else if (start_ok) begin
      phase_q <= i_phase_w;
      gap_q   <= i_gap_w;
      ipi_q   <= i_ipi_w;
      num_q   <= i_num_pulses;
      pol_q   <= i_polarity;
    end
  end

  assign out_sw1_sig     = sw_q[3];
  assign out_sw2_sig     = sw_q[2];
  assign out_sw3_sig     = sw_q[1];
  assign out_sw4_sig     = sw_q[0];
  assign output_ctrl_sig = ctrl_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule
